drop_controller: RTL and testbench

Game-sequencing stage directly downstream of the LedCatch random-number and bit-selector stages. Takes a random column (0-7) and animates a single falling LED down an 8x8 frame buffer, one row per DROP_TICKS game ticks. Writes each erase/draw to the frame-buffer write port through a valid/ready handshake. At the bottom row it judges catch/miss against the player paddle bitmap, keeps score and miss count, and signals game over.

---
 rtl/ledcatch_pkg.sv | 29 ++
 rtl/drop_tick_div.sv | 41 ++++
 rtl/drop_controller.sv | 173 +++++++++++++++++
 tb/tb_drop_controller.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledcatch_pkg.sv
// rtl/ledcatch_pkg.sv - shared types and constants for the LedCatch game stages
//
// Purpose: state encoding for the drop sequencer, matrix geometry defaults,
//          frame-buffer port widths and the column-to-mask helper.
// Ports:   none (package).

package ledcatch_pkg;

  localparam int ROWS_DEF       = 8;
  localparam int ROW_STRIDE_DEF = 8;
  localparam int FB_ADDR_W      = 6;
  localparam int FB_DATA_W      = 8;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN_WR,
    WAIT,
    ERASE_WR,
    DRAW_WR,
    JUDGE,
    OVER
  } state_t;

  // One lit LED at the given column of a row.
  function automatic logic [FB_DATA_W-1:0] col_mask(input logic [2:0] col);
    return FB_DATA_W'(1) << col;
  endfunction

endpackage

// File: rtl/drop_tick_div.sv
// rtl/drop_tick_div.sv - divides game ticks down to one-row fall steps
//
// Purpose: counts tick pulses and emits step on the DROP_TICKS-th one,
//          restarting from zero. clear holds the count at zero.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   clear        : force count to zero (has priority over tick)
//   tick         : qualified tick pulse to count
//   step         : combinational, high with the tick that completes a period

module drop_tick_div
  import ledcatch_pkg::*;
#(
  parameter int DROP_TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic tick,
  output logic step
);

  localparam int CNT_W = (DROP_TICKS > 1) ? $clog2(DROP_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DROP_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  // clear wins so that a tick in a cleared cycle never produces a step.
  assign step = tick && !clear && (cnt == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || step) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/drop_controller.sv
// rtl/drop_controller.sv - falling-LED sequencer with catch/miss judging
//
// Purpose: spawns an LED at a random column on the top row, moves it down one
//          row every DROP_TICKS ticks through frame-buffer erase/draw writes,
//          judges it against the paddle at the bottom, keeps score and misses
//          and stops the game after MAX_MISSES misses.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   start          : begin/restart a game (honoured in IDLE and OVER only)
//   tick           : game-rate pulse (counted in WAIT only)
//   spawn_col      : column latched on entry to SPAWN_WR
//   paddle         : bottom-row paddle bitmap, sampled in JUDGE
//   fb_addr/fb_data: frame-buffer write address / row pattern
//   fb_we/fb_ready : write valid / ready handshake
//   score          : saturating catch count
//   miss_count     : misses this game
//   catch_pulse    : one cycle per catch
//   miss_pulse     : one cycle per miss
//   game_over      : high while in OVER

module drop_controller
  import ledcatch_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int ROW_STRIDE = ROW_STRIDE_DEF,
  parameter int DROP_TICKS = 4,
  parameter int MAX_MISSES = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 tick,
  input  logic [2:0]           spawn_col,
  input  logic [7:0]           paddle,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [FB_DATA_W-1:0] fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic [7:0]           score,
  output logic [3:0]           miss_count,
  output logic                 catch_pulse,
  output logic                 miss_pulse,
  output logic                 game_over
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [ROW_W-1:0]       row;
  logic [2:0]             col;
  logic                   over_pending;
  logic                   step;
  logic                   xfer;
  logic                   at_bottom;
  logic                   start_ok;
  logic [FB_ADDR_W-1:0]   row_addr;

  assign xfer      = fb_we && fb_ready;
  assign at_bottom = (row == LAST_ROW);
  assign start_ok  = start && ((state == IDLE) || (state == OVER));
  assign row_addr  = FB_ADDR_W'(row) * FB_ADDR_W'(ROW_STRIDE);
  assign game_over = (state == OVER);

  // Ticks outside WAIT are dropped, and the count restarts on every WAIT entry.
  drop_tick_div #(
    .DROP_TICKS(DROP_TICKS)
  ) u_tick_div (
    .clock(clock),
    .reset(reset),
    .clear(state != WAIT),
    .tick (tick),
    .step (step)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fb_we      = 1'b0;
    fb_addr    = '0;
    fb_data    = '0;
    case (state)
      IDLE: begin
        if (start) state_next = SPAWN_WR;
      end
      SPAWN_WR: begin
        fb_we   = 1'b1;
        fb_addr = row_addr;
        fb_data = col_mask(col);
        if (xfer) state_next = WAIT;
      end
      WAIT: begin
        if (step) state_next = at_bottom ? JUDGE : ERASE_WR;
      end
      ERASE_WR: begin
        fb_we   = 1'b1;
        fb_addr = row_addr;
        if (xfer) begin
          if (at_bottom) state_next = over_pending ? OVER : SPAWN_WR;
          else           state_next = DRAW_WR;
        end
      end
      DRAW_WR: begin
        fb_we   = 1'b1;
        fb_addr = row_addr;
        fb_data = col_mask(col);
        if (xfer) state_next = WAIT;
      end
      JUDGE: begin
        state_next = ERASE_WR;
      end
      OVER: begin
        if (start) state_next = SPAWN_WR;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row          <= '0;
      col          <= '0;
      over_pending <= 1'b0;
      score        <= '0;
      miss_count   <= '0;
      catch_pulse  <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      catch_pulse <= 1'b0;
      miss_pulse  <= 1'b0;

      // Every path into SPAWN_WR (new game or next drop) picks a fresh column.
      if ((state_next == SPAWN_WR) && (state != SPAWN_WR)) begin
        col <= spawn_col;
        row <= '0;
      end

      if (start_ok) begin
        score        <= '0;
        miss_count   <= '0;
        over_pending <= 1'b0;
      end

      if ((state == ERASE_WR) && xfer && !at_bottom) begin
        row <= row + 1'b1;
      end

      // The game ends only after the bottom-row erase, so the miss is
      // latched here and acted on when that erase completes.
      if (state == JUDGE) begin
        if (paddle[col]) begin
          if (score != 8'hFF) score <= score + 8'd1;
          catch_pulse <= 1'b1;
        end else begin
          miss_count <= miss_count + 4'd1;
          miss_pulse <= 1'b1;
          if ((miss_count + 4'd1) == 4'(MAX_MISSES)) over_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_drop_controller.sv
// tb/tb_drop_controller.sv - self-checking bench for drop_controller

module tb_drop_controller;

  localparam int TICKS    = 4;
  localparam int LAST_ROW = 7;
  localparam int STRIDE   = 8;
  localparam int MAXM     = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [2:0] spawn_col;
  logic [7:0] paddle;
  logic [5:0] fb_addr;
  logic [7:0] fb_data;
  logic       fb_we;
  logic       fb_ready;
  logic [7:0] score;
  logic [3:0] miss_count;
  logic       catch_pulse;
  logic       miss_pulse;
  logic       game_over;

  always #5 clock = ~clock;

  drop_controller dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .tick       (tick),
    .spawn_col  (spawn_col),
    .paddle     (paddle),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .fb_we      (fb_we),
    .fb_ready   (fb_ready),
    .score      (score),
    .miss_count (miss_count),
    .catch_pulse(catch_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over)
  );

  typedef struct packed {
    logic [5:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests   = 0;
  int  n_fail    = 0;
  int  obs_catch = 0;
  int  obs_miss  = 0;
  int  exp_catch = 0;
  int  exp_miss  = 0;

  bit  m_active  = 0;
  bit  m_over    = 0;
  bit  m_pending = 0;
  int  m_row     = 0;
  int  m_col     = 0;
  int  m_tcnt    = 0;
  int  m_score   = 0;
  int  m_miss    = 0;

  function automatic void push_wr(int a, int d);
    wr_t w;
    w.a = 6'(a);
    w.d = 8'(d);
    exp_q.push_back(w);
  endfunction

  // Reference model of one tick arriving while the drop is waiting.
  function automatic void model_tick();
    if (!m_active || m_over) return;
    m_tcnt++;
    if (m_tcnt < TICKS) return;
    m_tcnt = 0;
    if (m_row < LAST_ROW) begin
      push_wr(m_row * STRIDE, 0);
      m_row++;
      push_wr(m_row * STRIDE, 1 << m_col);
    end else begin
      if (paddle[m_col]) begin
        if (m_score < 255) m_score++;
        exp_catch++;
      end else begin
        m_miss++;
        exp_miss++;
        if (m_miss == MAXM) m_pending = 1;
      end
      push_wr(LAST_ROW * STRIDE, 0);
      if (m_pending) begin
        m_over = 1;
      end else begin
        m_col = spawn_col;
        m_row = 0;
        push_wr(0, 1 << m_col);
      end
    end
  endfunction

  // Advance one clock; any write accepted on this edge is scored first.
  task automatic step_clk();
    wr_t w;
    if (!reset) begin
      if (catch_pulse) obs_catch++;
      if (miss_pulse)  obs_miss++;
      if (fb_we && fb_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fb_write_unexpected: got addr=%0d data=%02h, required no write", fb_addr, fb_data);
        end else begin
          w = exp_q.pop_front();
          if ({fb_addr, fb_data} !== {w.a, w.d}) begin
            n_fail++;
            $display("FAIL fb_write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                     fb_addr, fb_data, w.a, w.d);
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic tick_once();
    tick = 1'b1;
    model_tick();
    step_clk();
    tick = 1'b0;
    repeat (3) step_clk();
  endtask

  task automatic run_drop();
    repeat ((LAST_ROW + 1) * TICKS) tick_once();
  endtask

  task automatic start_game(input bit with_tick);
    logic [7:0] mask;
    start     = 1'b1;
    tick      = with_tick;
    m_active  = 1;
    m_over    = 0;
    m_pending = 0;
    m_score   = 0;
    m_miss    = 0;
    m_row     = 0;
    m_tcnt    = 0;
    m_col     = spawn_col;
    mask      = 8'(1 << m_col);
    push_wr(0, mask);
    step_clk();
    start = 1'b0;
    tick  = 1'b0;
    n_tests++;
    if ({fb_we, fb_addr, fb_data} !== {1'b1, 6'd0, mask}) begin
      n_fail++;
      $display("FAIL start_latency: got we=%0b addr=%0d data=%02h, required we=1 addr=0 data=%02h",
               fb_we, fb_addr, fb_data, mask);
    end
    repeat (2) step_clk();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    start     = 1'b0;
    tick      = 1'b0;
    spawn_col = 3'd0;
    paddle    = 8'h00;
    fb_ready  = 1'b1;
    repeat (2) step_clk();
    n_tests++;
    if ({fb_we, fb_addr, fb_data, score, miss_count, catch_pulse, miss_pulse, game_over} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%0b addr=%0d data=%02h score=%0d miss=%0d go=%0b, required all 0",
               fb_we, fb_addr, fb_data, score, miss_count, game_over);
    end
    reset = 1'b0;
    step_clk();
    repeat (2) tick_once();
    n_tests++;
    if ({fb_we, game_over} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_tick_ignored: got we=%0b go=%0b, required 0 0", fb_we, game_over);
    end
  endtask

  task automatic test_spawn_fall();
    spawn_col = 3'd3;
    start_game(1'b1);
    repeat (LAST_ROW * TICKS) tick_once();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL fall_writes_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_catch();
    paddle    = 8'h18;
    spawn_col = 3'd5;
    repeat (TICKS) tick_once();
    n_tests++;
    if (score !== 8'd1) begin
      n_fail++;
      $display("FAIL catch_score: got %0d, required 1", score);
    end
    n_tests++;
    if (obs_catch !== exp_catch || obs_miss !== exp_miss) begin
      n_fail++;
      $display("FAIL catch_pulses: got catch=%0d miss=%0d, required catch=%0d miss=%0d",
               obs_catch, obs_miss, exp_catch, exp_miss);
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL catch_writes_pending: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_stall();
    logic [5:0] s_addr;
    logic [7:0] s_data;
    repeat (TICKS - 1) tick_once();
    tick = 1'b1;
    model_tick();
    s_addr = 6'(m_row * STRIDE);
    s_data = 8'(1 << m_col);
    step_clk();
    tick = 1'b0;
    step_clk();
    fb_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = i[0];
      n_tests++;
      if ({fb_we, fb_addr, fb_data} !== {1'b1, s_addr, s_data}) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got we=%0b addr=%0d data=%02h, required we=1 addr=%0d data=%02h",
                 i, fb_we, fb_addr, fb_data, s_addr, s_data);
      end
      step_clk();
    end
    tick     = 1'b0;
    fb_ready = 1'b1;
    step_clk();
    n_tests++;
    if (fb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: got we=%0b, required 0", fb_we);
    end
    repeat (2) step_clk();
  endtask

  task automatic test_miss_over();
    int guard;
    paddle    = 8'h00;
    spawn_col = 3'd2;
    guard     = 0;
    while (!m_over && guard < 400) begin
      tick_once();
      guard++;
    end
    n_tests++;
    if (!m_over) begin
      n_fail++;
      $display("FAIL miss_budget: got no game end after %0d ticks, required end", guard);
    end
    n_tests++;
    if ({game_over, miss_count} !== {1'b1, 4'd3}) begin
      n_fail++;
      $display("FAIL miss_over: got go=%0b miss=%0d, required go=1 miss=3", game_over, miss_count);
    end
    n_tests++;
    if (obs_miss !== exp_miss || exp_miss !== 3) begin
      n_fail++;
      $display("FAIL miss_pulses: got %0d, required 3", obs_miss);
    end
    repeat (6) tick_once();
    n_tests++;
    if ({fb_we, game_over} !== 2'b01 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL over_halt: got we=%0b go=%0b pending=%0d, required we=0 go=1 pending=0",
               fb_we, game_over, exp_q.size());
    end
    spawn_col = 3'd6;
    start_game(1'b0);
    n_tests++;
    if ({game_over, score, miss_count} !== 13'd0) begin
      n_fail++;
      $display("FAIL restart: got go=%0b score=%0d miss=%0d, required 0 0 0", game_over, score, miss_count);
    end
  endtask

  task automatic test_saturation();
    int c0;
    paddle = 8'hFF;
    repeat (255) run_drop();
    n_tests++;
    if (score !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_reach: got %0d, required 255", score);
    end
    c0 = obs_catch;
    run_drop();
    n_tests++;
    if (score !== 8'd255) begin
      n_fail++;
      $display("FAIL sat_hold: got %0d, required 255", score);
    end
    n_tests++;
    if (obs_catch !== c0 + 1) begin
      n_fail++;
      $display("FAIL sat_pulse: got %0d pulses, required %0d", obs_catch, c0 + 1);
    end
  endtask

  task automatic test_reset_midwrite();
    repeat (TICKS - 1) tick_once();
    fb_ready = 1'b0;
    tick     = 1'b1;
    step_clk();
    tick = 1'b0;
    n_tests++;
    if ({fb_we, fb_data} !== {1'b1, 8'h00}) begin
      n_fail++;
      $display("FAIL erase_stall: got we=%0b data=%02h, required we=1 data=00", fb_we, fb_data);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({fb_we, fb_addr, fb_data, score, miss_count, catch_pulse, miss_pulse, game_over} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got we=%0b addr=%0d data=%02h score=%0d miss=%0d go=%0b, required all 0",
               fb_we, fb_addr, fb_data, score, miss_count, game_over);
    end
    exp_q.delete();
    m_active = 0;
    m_over   = 0;
    repeat (2) step_clk();
    reset    = 1'b0;
    fb_ready = 1'b1;
    repeat (5) tick_once();
    n_tests++;
    if ({fb_we, game_over} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got we=%0b go=%0b, required 0 0", fb_we, game_over);
    end
    spawn_col = 3'd1;
    start_game(1'b0);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL post_reset_spawn: got %0d outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_spawn_fall();
    test_catch();
    test_stall();
    test_miss_over();
    test_saturation();
    test_reset_midwrite();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
